quant_4x4: RTL

- Forward quantizer for 4x4 integer-transform coefficient blocks; sits directly downstream of the 4x4 forward transform and feeds entropy coding.
- Accepts one 16-coefficient block and its QP through a valid/ready handshake.
- Quantizes one row (4 lanes) per cycle using the H.264 MF/qbits scheme.
- Presents the 16 signed levels with valid/ready back-pressure.

---
 rtl/quant_pkg.sv | 48 ++++
 rtl/quant_lane.sv | 41 ++++
 rtl/quant_4x4.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/quant_pkg.sv
// Shared types, constants and helpers for the 4x4 forward quantizer.
package quant_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_QUANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CLS_A = 2'd0,
    CLS_B = 2'd1,
    CLS_C = 2'd2
  } pos_class_e;

  localparam logic [5:0] QP_MAX = 6'd51;

  // Multiplication factors indexed by [position class][qp % 6].
  localparam logic [13:0] MF_TABLE [3][6] = '{
    '{14'd13107, 14'd11916, 14'd10082, 14'd9362, 14'd8192, 14'd7282},
    '{14'd5243,  14'd4660,  14'd4194,  14'd3647, 14'd3355, 14'd2893},
    '{14'd8066,  14'd7490,  14'd6554,  14'd5825, 14'd5243, 14'd4559}
  };

  function automatic pos_class_e pos_class(input logic [1:0] row, input logic [1:0] col);
    pos_class_e cls;
    if (!row[0] && !col[0]) begin
      cls = CLS_A;
    end else if (row[0] && col[0]) begin
      cls = CLS_B;
    end else begin
      cls = CLS_C;
    end
    return cls;
  endfunction

  // Rounding offset: 2^qbits/3 for intra blocks, 2^qbits/6 for inter blocks.
  function automatic logic [23:0] round_offset(input logic [4:0] qbits, input logic intra);
    logic [24:0] pow2;
    pow2 = 25'd1 << qbits;
    if (intra) begin
      return 24'(pow2 / 25'd3);
    end else begin
      return 24'(pow2 / 25'd6);
    end
  endfunction

endpackage

// File: rtl/quant_lane.sv
// Combinational single-coefficient quantizer: level = sign(W) * ((|W|*MF + f) >> qbits).
module quant_lane
  import quant_pkg::*;
#(
  parameter int BIT_LENGTH = 31
) (
  input  logic signed [BIT_LENGTH:0] w_i,
  input  logic        [13:0]         mf_i,
  input  logic        [4:0]          qbits_i,
  input  logic        [23:0]         f_i,
  output logic signed [BIT_LENGTH:0] level_o
);

  localparam int PW = BIT_LENGTH + 16;
  localparam logic [BIT_LENGTH:0] ONE = {{BIT_LENGTH{1'b0}}, 1'b1};

  logic [BIT_LENGTH:0] mag_s;
  logic [BIT_LENGTH:0] zmag_s;
  logic [PW-1:0]       prod_s;
  logic [PW-1:0]       scaled_s;
  logic                unused_hi_s;

  // Magnitude is held unsigned so the most negative input maps to 2^BIT_LENGTH.
  always_comb begin
    if (w_i[BIT_LENGTH]) begin
      mag_s = ~w_i + ONE;
    end else begin
      mag_s = w_i;
    end
    prod_s      = PW'(mag_s) * PW'(mf_i) + PW'(f_i);
    scaled_s    = prod_s >> qbits_i;
    zmag_s      = scaled_s[BIT_LENGTH:0];
    unused_hi_s = ^scaled_s[PW-1:BIT_LENGTH+1];
    if (w_i[BIT_LENGTH]) begin
      level_o = ~zmag_s + ONE;
    end else begin
      level_o = zmag_s;
    end
  end

endmodule

// File: rtl/quant_4x4.sv
// 4x4 block forward quantizer, one row per cycle, valid/ready on both sides.
// Optional nonzero-level count output is enabled by defining QUANT_NZ_COUNT_EN.
module quant_4x4
  import quant_pkg::*;
#(
  parameter int BIT_LENGTH = 31,
  parameter int QP_WIDTH   = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [BIT_LENGTH:0] coeffs [16],
  input  logic        [QP_WIDTH-1:0] qp,
  input  logic                       intra,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [BIT_LENGTH:0] levels [16]
`ifdef QUANT_NZ_COUNT_EN
  ,
  output logic        [4:0]          nz_count
`endif
);

  state_e                    state_q, state_d;
  logic [1:0]                row_q, row_d;
  logic signed [BIT_LENGTH:0] coeff_q [16];
  logic signed [BIT_LENGTH:0] coeff_d [16];
  logic [5:0]                qp_q, qp_d;
  logic                      intra_q, intra_d;
  logic signed [BIT_LENGTH:0] levels_q [16];
  logic signed [BIT_LENGTH:0] levels_d [16];
  logic                      out_valid_q, out_valid_d;

  logic [5:0]                qp_clamp_s;
  logic [2:0]                qm_s;
  logic [3:0]                qe_s;
  logic [4:0]                qbits_s;
  logic [23:0]               f_s;
  logic [13:0]               lane_mf_s [4];
  logic signed [BIT_LENGTH:0] lane_level_s [4];

`ifdef QUANT_NZ_COUNT_EN
  logic [4:0]                nz_q, nz_d;
  logic [2:0]                row_nz_s;
`endif

  // Quantizer parameters derived from the latched qp and the current row.
  always_comb begin
    if (qp > QP_WIDTH'(QP_MAX)) begin
      qp_clamp_s = QP_MAX;
    end else begin
      qp_clamp_s = 6'(qp);
    end
    qm_s    = 3'(qp_q % 6'd6);
    qe_s    = 4'(qp_q / 6'd6);
    qbits_s = 5'd15 + {1'b0, qe_s};
    f_s     = round_offset(qbits_s, intra_q);
    for (int c = 0; c < 4; c++) begin
      lane_mf_s[c] = MF_TABLE[pos_class(row_q, 2'(c))][qm_s];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_lane
    quant_lane #(.BIT_LENGTH(BIT_LENGTH)) u_lane (
      .w_i     (coeff_q[{row_q, 2'(c)}]),
      .mf_i    (lane_mf_s[c]),
      .qbits_i (qbits_s),
      .f_i     (f_s),
      .level_o (lane_level_s[c])
    );
  end

`ifdef QUANT_NZ_COUNT_EN
  // Nonzero levels produced by the current row.
  always_comb begin
    row_nz_s = 3'd0;
    for (int c = 0; c < 4; c++) begin
      if (lane_level_s[c] != '0) begin
        row_nz_s = row_nz_s + 3'd1;
      end else begin
        row_nz_s = row_nz_s;
      end
    end
  end
`endif

  // Next-state logic for the accept / quantize / hold sequence.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    coeff_d     = coeff_q;
    qp_d        = qp_q;
    intra_d     = intra_q;
    levels_d    = levels_q;
    out_valid_d = out_valid_q;
`ifdef QUANT_NZ_COUNT_EN
    nz_d        = nz_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          coeff_d = coeffs;
          qp_d    = qp_clamp_s;
          intra_d = intra;
          row_d   = 2'd0;
          state_d = ST_QUANT;
`ifdef QUANT_NZ_COUNT_EN
          nz_d    = 5'd0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_QUANT: begin
        for (int c = 0; c < 4; c++) begin
          levels_d[{row_q, 2'(c)}] = lane_level_s[c];
        end
        row_d = row_q + 2'd1;
`ifdef QUANT_NZ_COUNT_EN
        nz_d  = nz_q + {2'd0, row_nz_s};
`endif
        if (row_q == 2'd3) begin
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          state_d     = ST_QUANT;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_HOLD;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any block in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      row_q       <= 2'd0;
      coeff_q     <= '{default: '0};
      qp_q        <= 6'd0;
      intra_q     <= 1'b0;
      levels_q    <= '{default: '0};
      out_valid_q <= 1'b0;
`ifdef QUANT_NZ_COUNT_EN
      nz_q        <= 5'd0;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      coeff_q     <= coeff_d;
      qp_q        <= qp_d;
      intra_q     <= intra_d;
      levels_q    <= levels_d;
      out_valid_q <= out_valid_d;
`ifdef QUANT_NZ_COUNT_EN
      nz_q        <= nz_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign levels    = levels_q;
`ifdef QUANT_NZ_COUNT_EN
  assign nz_count  = nz_q;
`endif

endmodule
